// File: rtl/mag_window_stats.sv
// Windowed peak/mean statistics over 2^LOG2_WIN magnitude samples, with a
// hysteresis alarm driven from each completed window's peak.
module mag_window_stats #(
    parameter int WIDTH     = 8,
    parameter int LOG2_WIN  = 3,
    parameter int THRESH_HI = 200,
    parameter int THRESH_LO = 150
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_peak,
    output logic [WIDTH-1:0] out_mean,
    output logic             alarm
);

    localparam int SUMW = WIDTH + LOG2_WIN;
    localparam logic [WIDTH-1:0] THR_HI = WIDTH'(THRESH_HI);
    localparam logic [WIDTH-1:0] THR_LO = WIDTH'(THRESH_LO);

    typedef enum logic {QUIET, ALARM} state_t;

    logic [LOG2_WIN-1:0] cnt_q, cnt_d;
    logic [SUMW-1:0]     sum_q, sum_d;
    logic [WIDTH-1:0]    run_peak_q, run_peak_d;
    logic [WIDTH-1:0]    out_peak_q, out_peak_d;
    logic [WIDTH-1:0]    out_mean_q, out_mean_d;
    logic                out_valid_q, out_valid_d;
    state_t              state_q, state_d;

    logic                last;
    logic                accept;
    logic [WIDTH-1:0]    new_peak;
    logic [SUMW-1:0]     new_sum;

    assign last     = (cnt_q == '1);
    // Only the completing sample stalls, and only while an undelivered result is held.
    assign in_ready = !clear && !(last && out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;
    assign new_peak = (in_mag > run_peak_q) ? in_mag : run_peak_q;
    assign new_sum  = sum_q + SUMW'(in_mag);

    always_comb begin
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        run_peak_d  = run_peak_q;
        out_peak_d  = out_peak_q;
        out_mean_d  = out_mean_q;
        out_valid_d = out_valid_q;
        state_d     = state_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clear) begin
            cnt_d      = '0;
            sum_d      = '0;
            run_peak_d = '0;
        end else if (accept) begin
            if (last) begin
                cnt_d       = '0;
                sum_d       = '0;
                run_peak_d  = '0;
                out_peak_d  = new_peak;
                out_mean_d  = new_sum[SUMW-1:LOG2_WIN];
                out_valid_d = 1'b1;
                case (state_q)
                    QUIET:   if (new_peak >= THR_HI) state_d = ALARM;
                    ALARM:   if (new_peak <  THR_LO) state_d = QUIET;
                    default: state_d = QUIET;
                endcase
            end else begin
                cnt_d      = cnt_q + 1'b1;
                sum_d      = new_sum;
                run_peak_d = new_peak;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            sum_q       <= '0;
            run_peak_q  <= '0;
            out_peak_q  <= '0;
            out_mean_q  <= '0;
            out_valid_q <= 1'b0;
            state_q     <= QUIET;
        end else begin
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            run_peak_q  <= run_peak_d;
            out_peak_q  <= out_peak_d;
            out_mean_q  <= out_mean_d;
            out_valid_q <= out_valid_d;
            state_q     <= state_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_peak  = out_peak_q;
    assign out_mean  = out_mean_q;
    assign alarm     = (state_q == ALARM);

endmodule

// File: tb/tb_mag_window_stats.sv
// Directed scoreboard bench for mag_window_stats: expected window results are
// queued when the completing sample is accepted and checked on output handshake.
module tb_mag_window_stats;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_mag = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_peak;
    logic [7:0] out_mean;
    logic       alarm;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] peak;
        logic [7:0] mean;
        logic       alarm;
    } exp_t;

    exp_t q[$];

    int          m_cnt = 0;
    int          m_sum = 0;
    int          m_peak = 0;
    logic        m_alarm = 1'b0;

    mag_window_stats #(
        .WIDTH(8),
        .LOG2_WIN(3),
        .THRESH_HI(200),
        .THRESH_LO(150)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_mag(in_mag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_peak(out_peak),
        .out_mean(out_mean),
        .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset_window();
        m_cnt  = 0;
        m_sum  = 0;
        m_peak = 0;
    endtask

    task automatic model_accept(input int m);
        exp_t e;
        m_sum  = m_sum + m;
        m_peak = (m > m_peak) ? m : m_peak;
        if (m_cnt == 7) begin
            if (!m_alarm && m_peak >= 200) m_alarm = 1'b1;
            else if (m_alarm && m_peak < 150) m_alarm = 1'b0;
            e.peak  = 8'(m_peak);
            e.mean  = 8'(m_sum / 8);
            e.alarm = m_alarm;
            q.push_back(e);
            model_reset_window();
        end else begin
            m_cnt++;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] m);
        bit done = 0;
        in_valid = 1'b1;
        in_mag   = m;
        for (int n = 0; n < 50 && !done; n++) begin
            #1;
            if (in_ready) begin
                model_accept(int'(m));
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("send_timeout", 32'(done), 32'd1);
    endtask

    task automatic send_n(input int n, input logic [7:0] m);
        for (int i = 0; i < n; i++) send(m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            checks++;
            assert (q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_output: observed peak=%0d mean=%0d expected=none", out_peak, out_mean);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_peak", 32'(out_peak), 32'(e.peak));
                chk("sb_mean", 32'(out_mean), 32'(e.mean));
                chk("sb_alarm", 32'(alarm), 32'(e.alarm));
            end
        end
    end

    logic [7:0] gap_vals [8];

    initial begin
        // Reset
        idle(2);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_peak", 32'(out_peak), 32'd0);
        chk("rst_out_mean", 32'(out_mean), 32'd0);
        chk("rst_alarm", 32'(alarm), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Ramp window 10..80
        for (int i = 1; i <= 8; i++) send(8'(i * 10));
        chk("ramp_valid_now", 32'(out_valid), 32'd1);
        idle(1);
        chk("ramp_valid_one_cycle", 32'(out_valid), 32'd0);

        // Alarm hysteresis
        send_n(8, 8'd255);
        chk("alarm_set", 32'(alarm), 32'd1);
        send_n(8, 8'd170);
        chk("alarm_hold_hi", 32'(alarm), 32'd1);
        send_n(8, 8'd100);
        chk("alarm_clear", 32'(alarm), 32'd0);
        send_n(8, 8'd170);
        chk("alarm_hold_lo", 32'(alarm), 32'd0);
        idle(2);

        // Backpressure: 15 samples go through, the 16th stalls
        out_ready = 1'b0;
        send_n(15, 8'd50);
        in_valid = 1'b1;
        in_mag   = 8'd50;
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        chk("stall_hold", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("stall_release_ready", 32'(in_ready), 32'd1);
        model_accept(50);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("drain_and_fill_valid", 32'(out_valid), 32'd1);
        idle(1);
        chk("second_result_pending", 32'(q.size()), 32'd1);
        out_ready = 1'b1;
        idle(2);

        // Clear discards a partial window
        send_n(3, 8'd200);
        clear = 1'b1;
        #1;
        chk("clear_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        model_reset_window();
        send_n(8, 8'd40);
        idle(2);

        // Reset discards a pending result and a partial window
        out_ready = 1'b0;
        send_n(8, 8'd200);
        chk("thresh_hi_exact", 32'(alarm), 32'd1);
        send_n(4, 8'd30);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        model_reset_window();
        m_alarm = 1'b0;
        chk("rst2_out_valid", 32'(out_valid), 32'd0);
        chk("rst2_out_peak", 32'(out_peak), 32'd0);
        chk("rst2_out_mean", 32'(out_mean), 32'd0);
        chk("rst2_alarm", 32'(alarm), 32'd0);
        out_ready = 1'b1;
        for (int i = 1; i <= 7; i++) send(8'(i));
        idle(2);
        chk("rst2_partial_no_output", 32'(out_valid), 32'd0);
        send(8'd8);
        idle(2);

        // Gapped input
        gap_vals = '{8'd7, 8'd0, 8'd3, 8'd9, 8'd1, 8'd1, 8'd2, 8'd5};
        for (int i = 0; i < 8; i++) begin
            idle(int'($urandom_range(0, 3)));
            send(gap_vals[i]);
        end
        idle(3);

        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
